reg_queue: RTL and testbench

//   Valid/ready FIFO whose outputs are fully registered, the counterpart of the zero-latency

---
 rtl/reg_queue.sv | 121 ++++++++++++
 tb/tb_reg_queue.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/reg_queue.sv
// reg_queue: valid/ready FIFO with fully registered outputs.
// A head register drives out_valid/out_data; a 2**QUEUE_DEPTH_WIDTH entry memory
// sits behind it, so total capacity is QUEUE_DEPTH + 1 words. in_ready is a flop
// computed from next-state occupancy, so no input reaches any output within a cycle.
module reg_queue #(
  parameter int QUEUE_DEPTH_WIDTH = 3,
  parameter int DATA_WIDTH        = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
);

  localparam int QUEUE_DEPTH = 1 << QUEUE_DEPTH_WIDTH;
  localparam int PW          = QUEUE_DEPTH_WIDTH + 1;
  localparam logic [PW-1:0] PTR_ONE = {{QUEUE_DEPTH_WIDTH{1'b0}}, 1'b1};

  // Pointers carry the wrap flag in their MSB: {flag, index}.
  function automatic logic ptr_empty(input logic [PW-1:0] wr, input logic [PW-1:0] rd);
    return (wr == rd);
  endfunction

  function automatic logic ptr_full(input logic [PW-1:0] wr, input logic [PW-1:0] rd);
    return (wr[QUEUE_DEPTH_WIDTH-1:0] == rd[QUEUE_DEPTH_WIDTH-1:0]) &&
           (wr[PW-1] != rd[PW-1]);
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [QUEUE_DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic                  head_valid_r;
  logic [DATA_WIDTH-1:0] head_data_r;
  logic                  in_ready_r;

  logic                  push_s;
  logic                  pop_s;
  logic                  refill_s;
  logic                  mem_empty_s;
  logic                  load_in_s;
  logic                  mem_we_s;
  logic [PW-1:0]         wr_ptr_nxt_s;
  logic [PW-1:0]         rd_ptr_nxt_s;
  logic                  head_valid_nxt_s;
  logic [DATA_WIDTH-1:0] head_data_nxt_s;
  logic                  in_ready_nxt_s;

  assign push_s      = in_valid && in_ready_r;
  assign pop_s       = head_valid_r && out_ready;
  assign refill_s    = !head_valid_r || pop_s;
  assign mem_empty_s = ptr_empty(wr_ptr_r, rd_ptr_r);

  // Next-state for head register, pointers and the registered in_ready.
  always_comb begin
    head_valid_nxt_s = head_valid_r;
    head_data_nxt_s  = head_data_r;
    rd_ptr_nxt_s     = rd_ptr_r;
    wr_ptr_nxt_s     = wr_ptr_r;
    load_in_s        = 1'b0;
    mem_we_s         = 1'b0;

    if (refill_s) begin
      if (!mem_empty_s) begin
        head_valid_nxt_s = 1'b1;
        head_data_nxt_s  = mem_r[rd_ptr_r[QUEUE_DEPTH_WIDTH-1:0]];
        rd_ptr_nxt_s     = rd_ptr_r + PTR_ONE;
      end else if (push_s) begin
        head_valid_nxt_s = 1'b1;
        head_data_nxt_s  = in_data;
        load_in_s        = 1'b1;
      end else begin
        head_valid_nxt_s = 1'b0;
      end
    end else begin
      head_valid_nxt_s = head_valid_r;
    end

    if (push_s && !load_in_s) begin
      mem_we_s     = 1'b1;
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      mem_we_s     = 1'b0;
    end

    // Reset clears in_ready_r, so the first edge after release acts as the run flag.
    in_ready_nxt_s = !(head_valid_nxt_s && ptr_full(wr_ptr_nxt_s, rd_ptr_nxt_s));
  end

  // Control state: pointers, head register and in_ready, async-cleared.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      head_valid_r <= 1'b0;
      head_data_r  <= {DATA_WIDTH{1'b0}};
      in_ready_r   <= 1'b0;
    end else begin
      wr_ptr_r     <= wr_ptr_nxt_s;
      rd_ptr_r     <= rd_ptr_nxt_s;
      head_valid_r <= head_valid_nxt_s;
      head_data_r  <= head_data_nxt_s;
      in_ready_r   <= in_ready_nxt_s;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_r[wr_ptr_r[QUEUE_DEPTH_WIDTH-1:0]] <= in_data;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = head_valid_r;
  assign out_data  = head_data_r;

endmodule

// File: tb/tb_reg_queue.sv
// Self-checking bench for reg_queue (QUEUE_DEPTH_WIDTH=1, DATA_WIDTH=16, capacity 3).
// Inputs are driven on the falling edge; registered outputs are sampled at the same point.
module tb_reg_queue;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;

  int n_cmp;
  int n_bad;

  reg_queue #(.QUEUE_DEPTH_WIDTH(1), .DATA_WIDTH(16)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        iv;
    logic [15:0] d;
    logic        ordy;
    logic        ir;
    logic        ov;
    logic [15:0] od;
  } vec_t;

  vec_t vecs [14];
  logic [15:0] sb [$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    int sent;
    int recv;
    int cyc;
    logic [15:0] front;
    n_cmp = 0;
    n_bad = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b0;

    // Latency, fill and full-drain vectors: expected outputs are seen in the row's cycle.
    vecs[0]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 16'h0011, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0011};
    vecs[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[4]  = '{1'b1, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[5]  = '{1'b1, 16'h0002, 1'b0, 1'b1, 1'b1, 16'h0001};
    vecs[6]  = '{1'b1, 16'h0003, 1'b0, 1'b1, 1'b1, 16'h0001};
    vecs[7]  = '{1'b1, 16'h0004, 1'b0, 1'b0, 1'b1, 16'h0001};
    vecs[8]  = '{1'b1, 16'h0004, 1'b0, 1'b0, 1'b1, 16'h0001};
    vecs[9]  = '{1'b1, 16'h0004, 1'b1, 1'b0, 1'b1, 16'h0001};
    vecs[10] = '{1'b1, 16'h0004, 1'b1, 1'b1, 1'b1, 16'h0002};
    vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0003};
    vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0004};
    vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};

    // Reset held for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("rst_out_valid[%0d]", i), {15'd0, out_valid}, 16'h0000);
      check($sformatf("rst_in_ready[%0d]", i), {15'd0, in_ready}, 16'h0000);
    end
    check("rst_out_data", out_data, 16'h0000);
    reset_n = 1'b1;
    #1;
    check("rel_in_ready_pre_edge", {15'd0, in_ready}, 16'h0000);
    @(negedge clock);
    check("rel_in_ready_post_edge", {15'd0, in_ready}, 16'h0001);

    // Table-driven latency/fill/drain.
    for (int i = 0; i < 14; i++) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].d;
      out_ready = vecs[i].ordy;
      check($sformatf("vec%0d_in_ready", i), {15'd0, in_ready}, {15'd0, vecs[i].ir});
      check($sformatf("vec%0d_out_valid", i), {15'd0, out_valid}, {15'd0, vecs[i].ov});
      if (vecs[i].ov) check($sformatf("vec%0d_out_data", i), out_data, vecs[i].od);
      @(negedge clock);
    end

    // Streaming: 100 words, expect 1 per cycle after the initial fill.
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 100 && cyc < 400) begin
      in_valid  = (sent < 100);
      in_data   = sent[15:0];
      out_ready = 1'b1;
      check($sformatf("stream_in_ready[%0d]", cyc), {15'd0, in_ready}, 16'h0001);
      if (out_valid) begin
        check($sformatf("stream_data[%0d]", recv), out_data, recv[15:0]);
        recv++;
      end else if (recv > 0) begin
        check($sformatf("stream_bubble[%0d]", recv), {15'd0, out_valid}, 16'h0001);
      end
      if (in_valid && in_ready) sent++;
      @(negedge clock);
      cyc++;
    end
    check("stream_count", recv[15:0], 16'd100);
    check("stream_cycles", cyc[15:0], 16'd101);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clock);

    // Random valid/ready over 50 words against a scoreboard.
    sent = 0;
    recv = 0;
    cyc  = 0;
    sb.delete();
    while (recv < 50 && cyc < 3000) begin
      in_valid  = (sent < 50) ? 1'($urandom_range(1, 0)) : 1'b0;
      in_data   = 16'h1000 + sent[15:0];
      out_ready = 1'($urandom_range(1, 0));
      check($sformatf("rand_in_ready[%0d]", cyc), {15'd0, in_ready},
            {15'd0, (sb.size() != 3)});
      check($sformatf("rand_out_valid[%0d]", cyc), {15'd0, out_valid},
            {15'd0, (sb.size() != 0)});
      if (out_valid && out_ready) begin
        front = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
        check($sformatf("rand_data[%0d]", recv), out_data, front);
        recv++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(in_data);
        sent++;
      end
      @(negedge clock);
      cyc++;
    end
    check("rand_count", recv[15:0], 16'd50);
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Hold two entries, then pulse reset mid-cycle.
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = 16'hAAAA;
    @(negedge clock);
    in_data  = 16'hBBBB;
    @(negedge clock);
    in_valid = 1'b0;
    check("hold_out_valid", {15'd0, out_valid}, 16'h0001);
    check("hold_out_data", out_data, 16'hAAAA);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", {15'd0, out_valid}, 16'h0000);
    check("midrst_in_ready", {15'd0, in_ready}, 16'h0000);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("postrst_out_valid", {15'd0, out_valid}, 16'h0000);
    check("postrst_in_ready", {15'd0, in_ready}, 16'h0001);
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    @(negedge clock);
    in_valid = 1'b0;
    check("postrst_first_valid", {15'd0, out_valid}, 16'h0001);
    check("postrst_first_data", out_data, 16'hBEEF);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check("postrst_empty", {15'd0, out_valid}, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
